// File: rtl/vga_timing_gen.sv
// VGA scan timing: pixel divider, px/py counters, registered blanked RGB and active-low syncs.
// Optional macro VGA_TEST_PATTERN_EN adds a test_pattern input selecting 8 vertical colour bars.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       reset,
`ifdef VGA_TEST_PATTERN_EN
   input  logic       test_pattern,
`endif
   input  logic [3:0] rgb_red_in,
   input  logic [3:0] rgb_green_in,
   input  logic [3:0] rgb_blue_in,
   output logic [9:0] px,
   output logic [9:0] py,
   output logic       video_on,
   output logic       pix_tick,
   output logic       frame_start,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             run;
   logic             hs_active;
   logic             vs_active;
   logic [11:0]      out_rgb;

   // run holds the divider for one clk after reset so the first tick lands CLK_DIV clks later
   always_ff @(posedge clk) begin
      if (reset) begin
         run     <= 1'b0;
         div_cnt <= '0;
      end else begin
         run <= 1'b1;
         if (run) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         end
      end
   end

   assign pix_tick = run && (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         px <= '0;
         py <= '0;
      end else if (pix_tick) begin
         if (px == H_LAST) begin
            px <= '0;
            py <= (py == V_LAST) ? '0 : py + 10'd1;
         end else begin
            px <= px + 10'd1;
         end
      end
   end

   assign video_on  = (px < H_ACT) && (py < V_ACT);
   assign hs_active = (px >= HS_FIRST) && (px <= HS_LAST);
   assign vs_active = (py >= VS_FIRST) && (py <= VS_LAST);

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [9:0] bar;
   assign bar = px / BAR_W;
`endif

   always_comb begin
      out_rgb = {rgb_red_in, rgb_green_in, rgb_blue_in};
`ifdef VGA_TEST_PATTERN_EN
      if (test_pattern) begin
         case (bar)
            10'd0:   out_rgb = 12'hFFF;
            10'd1:   out_rgb = 12'hFF0;
            10'd2:   out_rgb = 12'h0FF;
            10'd3:   out_rgb = 12'h0F0;
            10'd4:   out_rgb = 12'hF0F;
            10'd5:   out_rgb = 12'hF00;
            10'd6:   out_rgb = 12'h00F;
            default: out_rgb = 12'h000;
         endcase
      end
`endif
      if (!video_on) out_rgb = '0;
   end

   // Output stage captures the pixel the counters are leaving, so pins lag px/py by one tick
   always_ff @(posedge clk) begin
      if (reset) begin
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_tick && (px == H_LAST) && (py == V_LAST);
         if (pix_tick) begin
            vga_r  <= out_rgb[11:8];
            vga_g  <= out_rgb[7:4];
            vga_b  <= out_rgb[3:0];
            vga_hs <= ~hs_active;
            vga_vs <= ~vs_active;
         end
      end
   end

endmodule
